// File: rtl/flash_word_reader.sv
// flash_word_reader: burst reader for the board's 8-bit parallel boot flash.
// Walks the flash byte address one byte at a time, holds each address for the
// programmed access time, packs four bytes big-endian into a 32-bit word and
// hands each word to the consumer with valid/ready backpressure.
module flash_word_reader #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_count,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_last,
  output logic        busy,
  output logic [21:0] FL_ADDR,
  input  logic [7:0]  FL_DQ,
  output logic        FL_CE_N,
  output logic        FL_OE_N,
  output logic        FL_WE_N,
  output logic        FL_RST_N
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    HOLD
  } state_t;

  // Counter value on which the byte currently on FL_DQ is taken.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t      state;
  logic [19:0] word_addr;
  logic [8:0]  remaining;
  logic [1:0]  byte_idx;
  logic [3:0]  wait_cnt;
  // Lanes [31:8] of the word being assembled; lane [7:0] comes straight
  // from FL_DQ on the edge that completes the word.
  logic [23:0] upper_bytes;

  // Request accept, byte sequencing with access-time wait, word hand-off.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= 32'd0;
      resp_last   <= 1'b0;
      busy        <= 1'b0;
      FL_ADDR     <= 22'd0;
      FL_CE_N     <= 1'b1;
      FL_OE_N     <= 1'b1;
      FL_WE_N     <= 1'b1;
      FL_RST_N    <= 1'b0;
      word_addr   <= 20'd0;
      remaining   <= 9'd0;
      byte_idx    <= 2'd0;
      wait_cnt    <= 4'd0;
      upper_bytes <= 24'd0;
    end else begin
      FL_RST_N <= 1'b1;
      FL_WE_N  <= 1'b1;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            word_addr <= req_addr;
            remaining <= (req_count == 8'd0) ? 9'd256 : {1'b0, req_count};
            byte_idx  <= 2'd0;
            wait_cnt  <= 4'd0;
            FL_ADDR   <= {req_addr, 2'b00};
            FL_CE_N   <= 1'b0;
            FL_OE_N   <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= ACCESS;
          end
        end

        ACCESS: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= 4'd0;
            if (byte_idx != 2'd3) begin
              case (byte_idx)
                2'd0:    upper_bytes[23:16] <= FL_DQ;
                2'd1:    upper_bytes[15:8]  <= FL_DQ;
                default: upper_bytes[7:0]   <= FL_DQ;
              endcase
              byte_idx     <= byte_idx + 2'd1;
              FL_ADDR[1:0] <= FL_ADDR[1:0] + 2'd1;
            end else begin
              resp_data  <= {upper_bytes, FL_DQ};
              resp_valid <= 1'b1;
              resp_last  <= (remaining == 9'd1);
              state      <= HOLD;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        HOLD: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            if (remaining > 9'd1) begin
              remaining <= remaining - 9'd1;
              word_addr <= word_addr + 20'd1;
              FL_ADDR   <= {word_addr + 20'd1, 2'b00};
              byte_idx  <= 2'd0;
              wait_cnt  <= 4'd0;
              state     <= ACCESS;
            end else begin
              resp_last <= 1'b0;
              busy      <= 1'b0;
              FL_CE_N   <= 1'b1;
              FL_OE_N   <= 1'b1;
              req_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/flash_word_reader.md
Name: flash_word_reader

Overview:
- CPU-side initiator for the board's 8-bit parallel flash: the end of the flash byte interface that issues addresses and samples data.
- Accepts a burst request of N consecutive 32-bit words and walks FL_ADDR one byte at a time, honouring a programmable access time.
- Assembles each word big-endian and streams words out with valid/ready backpressure.
- Feeds the boot loader that copies program images from flash into SDRAM.

Parameters:
- WAIT_CYCLES, 3, extra cycles FL_ADDR is held before a byte is sampled; each byte occupies WAIT_CYCLES+1 cycles; legal range 0..15.

Ports:
- clk  in  1  system clock
- Reset_n  in  1  synchronous active-low reset
- req_valid  in  1  burst request present
- req_ready  out  1  reader idle and able to accept a request
- req_addr  in  20  starting word address (byte address = {req_addr,2'b00})
- req_count  in  8  number of words; 0 means 256
- resp_valid  out  1  resp_data holds an assembled word
- resp_ready  in  1  consumer accepts the word
- resp_data  out  32  assembled word
- resp_last  out  1  qualifies the final word of the burst
- busy  out  1  burst in progress
- FL_ADDR  out  22  flash byte address
- FL_DQ  in  8  flash read data
- FL_CE_N  out  1  chip enable, active low
- FL_OE_N  out  1  output enable, active low
- FL_WE_N  out  1  write enable, constant 1
- FL_RST_N  out  1  flash reset, active low

Behaviour:
- Reset values (Reset_n=0 at a rising edge): state IDLE; req_ready=1 after release; resp_valid=0; resp_data=0; resp_last=0; busy=0; FL_ADDR=0; FL_CE_N=1; FL_OE_N=1; FL_WE_N=1; FL_RST_N=0.
- FL_RST_N is registered and goes to 1 on the first edge with Reset_n=1.
- Reset asserted mid-burst aborts the burst immediately; no partial word is emitted.
- All outputs are registered.
- States: IDLE, ACCESS, HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch the word address; latch the count (0 loads as 256); set byte index=0; load FL_ADDR={req_addr,2'b00}; drive FL_CE_N=0, FL_OE_N=0, busy=1; clear the wait counter; go to ACCESS.
  - req_ready=0 in every state other than IDLE.
- ACCESS:
  - Wait counter increments each cycle.
  - When the counter equals WAIT_CYCLES, sample FL_DQ on that edge into a byte lane: index 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - FL_ADDR has then been stable for exactly WAIT_CYCLES+1 cycles.
  - If index<3: increment index and FL_ADDR[1:0], clear the counter, stay in ACCESS.
  - If index==3: load resp_data with the full word (the lane written this edge included); set resp_valid=1; set resp_last=1 if remaining count==1; go to HOLD.
- HOLD:
  - resp_data, resp_valid and resp_last stay stable while resp_ready=0.
  - FL_CE_N and FL_OE_N stay 0; no flash access occurs.
  - On resp_valid&resp_ready with remaining>1: decrement the count; increment the word address; FL_ADDR={next,2'b00}; clear index and counter; resp_valid=0; go to ACCESS.
  - On the last word: resp_valid=0; resp_last=0; busy=0; FL_CE_N=1; FL_OE_N=1; go to IDLE (req_ready=1 next cycle).
- Latency:
  - First byte sampled WAIT_CYCLES+1 edges after the accept edge.
  - resp_valid rises at the edge of the 4th sample, i.e. 4*(WAIT_CYCLES+1) edges after the accept edge.
  - With resp_ready held at 1, word k+1 follows word k by 4*(WAIT_CYCLES+1)+1 cycles.
- Word address wraps from 20'hFFFFF to 0 within a burst.
- A new request is never accepted in the same cycle as the final handshake.
- req_* inputs are ignored while busy.
- resp_data keeps its last value after the burst ends.

Test Plan:
- Reset: hold Reset_n=0 for 3 cycles mid-burst -> all outputs at reset values, FL_CE_N=1, no resp_valid pulse after release; FL_RST_N=1 one cycle after release.
- Single word: flash word0=32'h3C1D0040, WAIT_CYCLES=3, req_addr=0, req_count=1, resp_ready=1 -> FL_ADDR steps 0,1,2,3, each held 4 cycles; resp_valid and resp_last high together exactly 16 cycles after accept; resp_data=32'h3C1D0040; req_ready returns next cycle.
- Burst of 3 from req_addr=5 with words 11223344, 55667788, 99AABBCC -> FL_ADDR covers bytes 20..31 in order; three responses in order; resp_last only on 99AABBCC.
- Backpressure: resp_ready=0 for 10 cycles on word 1 of 2 -> resp_data stable, FL_ADDR frozen at 23 (last byte of word 5), no new flash access until the handshake.
- Wrap and count 0: req_addr=20'hFFFFF, req_count=2 -> second word read from FL_ADDR 0..3; separately, req_count=0 -> exactly 256 responses, last flagged.
- WAIT_CYCLES=0 build: each byte held 1 cycle; first word valid 4 cycles after accept; data matches the image.
